// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the PC sequencer slice: default widths, reset PC and
// the run/halt state encoding.
package cpu_pkg;

    localparam int          DEF_PC_WIDTH  = 32;
    localparam int          DEF_CNT_WIDTH = 16;
    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } seq_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational control-flow resolution: evaluates branch conditions and jump targets
// and selects the next PC by JR > J/JW > taken branch > sequential priority.
module pc_target_calc
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH = DEF_PC_WIDTH
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [PC_WIDTH-1:0] rs,
    input  logic [PC_WIDTH-1:0] rt,
    input  logic [15:0]         imm16,
    input  logic [25:0]         target26,
    input  logic                j,
    input  logic                jw,
    input  logic                jr,
    input  logic                beq,
    input  logic                bne,
    input  logic                bgez,
    output logic [PC_WIDTH-1:0] pc4,
    output logic [PC_WIDTH-1:0] next_pc,
    output logic                redirect,
    output logic                is_uncond,
    output logic                is_cond_taken
);

    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(32'd4);

    logic [PC_WIDTH-1:0] jr_target_s;
    logic [PC_WIDTH-1:0] j_target_s;
    logic [PC_WIDTH-1:0] br_target_s;
    logic                br_taken_s;
    logic                jump_s;

    assign pc4         = pc + PC_STEP;
    assign jr_target_s = {rs[PC_WIDTH-1:2], 2'b00};
    assign j_target_s  = {pc4[PC_WIDTH-1:28], target26, 2'b00};
    // Word offset sign-extended and scaled; the add wraps modulo 2^PC_WIDTH.
    assign br_target_s = pc4 + {{(PC_WIDTH-18){imm16[15]}}, imm16, 2'b00};

    assign jump_s     = j | jw | jr;
    assign br_taken_s = (beq  & (rs == rt))
                      | (bne  & (rs != rt))
                      | (bgez & ~rs[PC_WIDTH-1]);

    // Priority select of the next PC.
    always_comb begin
        next_pc = pc4;
        if (jr) begin
            next_pc = jr_target_s;
        end else if (j | jw) begin
            next_pc = j_target_s;
        end else if (br_taken_s) begin
            next_pc = br_target_s;
        end else begin
            next_pc = pc4;
        end
    end

    assign redirect      = (next_pc != pc4);
    assign is_uncond     = jump_s;
    // A jump in the same cycle wins, so the branch is not counted as well.
    assign is_cond_taken = ~jump_s & br_taken_s;

endmodule

// File: rtl/pc_sequencer.sv
// PC register, run/halt FSM and branch statistics counters; next-PC resolution is
// delegated to pc_target_calc.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH  = DEF_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = PC_WIDTH'(DEF_RESET_PC),
    parameter int                  CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_stall,
    input  logic                 in_halt,
    input  logic                 in_go,
    input  logic                 in_J,
    input  logic                 in_JW,
    input  logic                 in_JR,
    input  logic                 in_BEQ,
    input  logic                 in_BNE,
    input  logic                 in_BGEZ,
    input  logic [PC_WIDTH-1:0]  in_rs,
    input  logic [PC_WIDTH-1:0]  in_rt,
    input  logic [15:0]          in_imm16,
    input  logic [25:0]          in_target26,
    output logic [PC_WIDTH-1:0]  out_pc,
    output logic [PC_WIDTH-1:0]  out_link,
    output logic                 out_redirect,
    output logic                 out_taken,
    output logic                 out_halted,
    output logic [CNT_WIDTH-1:0] out_cnt_cycle,
    output logic [CNT_WIDTH-1:0] out_cnt_uncond,
    output logic [CNT_WIDTH-1:0] out_cnt_cond
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    seq_state_e          state_r;
    seq_state_e          state_next_s;
    logic [PC_WIDTH-1:0] pc_r;
    logic [PC_WIDTH-1:0] pc_next_s;
    logic [PC_WIDTH-1:0] pc4_s;
    logic [PC_WIDTH-1:0] calc_next_pc_s;
    logic                calc_redirect_s;
    logic                is_uncond_s;
    logic                is_cond_taken_s;
    logic                advance_s;
    logic                resume_s;
    logic                halted_s;
    logic                taken_r;
    logic [CNT_WIDTH-1:0] cnt_cycle_r;
    logic [CNT_WIDTH-1:0] cnt_uncond_r;
    logic [CNT_WIDTH-1:0] cnt_cond_r;

    pc_target_calc #(
        .PC_WIDTH (PC_WIDTH)
    ) u_target_calc (
        .pc            (pc_r),
        .rs            (in_rs),
        .rt            (in_rt),
        .imm16         (in_imm16),
        .target26      (in_target26),
        .j             (in_J),
        .jw            (in_JW),
        .jr            (in_JR),
        .beq           (in_BEQ),
        .bne           (in_BNE),
        .bgez          (in_BGEZ),
        .pc4           (pc4_s),
        .next_pc       (calc_next_pc_s),
        .redirect      (calc_redirect_s),
        .is_uncond     (is_uncond_s),
        .is_cond_taken (is_cond_taken_s)
    );

    // Run/halt state register.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: stall beats halt in RUN, resume beats halt in HALT.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (!in_stall && in_halt) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_HALT: begin
                if (in_go) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_HALT;
                end
            end
            default: state_next_s = ST_RUN;
        endcase
    end

    // Per-state controls: advance commits the resolved PC, resume steps past the halt.
    always_comb begin
        advance_s = 1'b0;
        resume_s  = 1'b0;
        halted_s  = 1'b0;
        case (state_r)
            ST_RUN: begin
                advance_s = !in_stall && !in_halt;
            end
            ST_HALT: begin
                halted_s = 1'b1;
                resume_s = in_go;
            end
            default: begin
                advance_s = 1'b0;
            end
        endcase
    end

    // PC source selection.
    always_comb begin
        pc_next_s = pc_r;
        if (advance_s) begin
            pc_next_s = calc_next_pc_s;
        end else if (resume_s) begin
            pc_next_s = pc4_s;
        end else begin
            pc_next_s = pc_r;
        end
    end

    // PC, taken pulse and statistics counters; counters only move on committed RUN cycles.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            pc_r         <= RESET_PC;
            taken_r      <= 1'b0;
            cnt_cycle_r  <= {CNT_WIDTH{1'b0}};
            cnt_uncond_r <= {CNT_WIDTH{1'b0}};
            cnt_cond_r   <= {CNT_WIDTH{1'b0}};
        end else begin
            pc_r    <= pc_next_s;
            taken_r <= advance_s & calc_redirect_s;
            if (advance_s) begin
                cnt_cycle_r <= cnt_cycle_r + CNT_ONE;
            end
            if (advance_s && is_uncond_s) begin
                cnt_uncond_r <= cnt_uncond_r + CNT_ONE;
            end
            if (advance_s && is_cond_taken_s) begin
                cnt_cond_r <= cnt_cond_r + CNT_ONE;
            end
        end
    end

    assign out_pc         = pc_r;
    assign out_link       = pc4_s;
    assign out_redirect   = advance_s & calc_redirect_s;
    assign out_taken      = taken_r;
    assign out_halted     = halted_s;
    assign out_cnt_cycle  = cnt_cycle_r;
    assign out_cnt_uncond = cnt_uncond_r;
    assign out_cnt_cond   = cnt_cond_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer with hand-written halt, stall,
// reset and counter-wrap sequences.
module tb_pc_sequencer;

    logic        in_clk;
    logic        in_rst;
    logic        in_stall;
    logic        in_halt;
    logic        in_go;
    logic        in_J;
    logic        in_JW;
    logic        in_JR;
    logic        in_BEQ;
    logic        in_BNE;
    logic        in_BGEZ;
    logic [31:0] in_rs;
    logic [31:0] in_rt;
    logic [15:0] in_imm16;
    logic [25:0] in_target26;
    logic [31:0] out_pc;
    logic [31:0] out_link;
    logic        out_redirect;
    logic        out_taken;
    logic        out_halted;
    logic [15:0] out_cnt_cycle;
    logic [15:0] out_cnt_uncond;
    logic [15:0] out_cnt_cond;

    int n_checks;
    int n_fail;

    logic [15:0] m_cycle;
    logic [15:0] m_unc;
    logic [15:0] m_cond;

    typedef struct {
        logic [31:0] pc0;
        logic [5:0]  strb;      // {J, JW, JR, BEQ, BNE, BGEZ}
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] exp_pc;
        logic        exp_redir;
        logic        exp_unc;
        logic        exp_cond;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    pc_sequencer dut (
        .in_clk         (in_clk),
        .in_rst         (in_rst),
        .in_stall       (in_stall),
        .in_halt        (in_halt),
        .in_go          (in_go),
        .in_J           (in_J),
        .in_JW          (in_JW),
        .in_JR          (in_JR),
        .in_BEQ         (in_BEQ),
        .in_BNE         (in_BNE),
        .in_BGEZ        (in_BGEZ),
        .in_rs          (in_rs),
        .in_rt          (in_rt),
        .in_imm16       (in_imm16),
        .in_target26    (in_target26),
        .out_pc         (out_pc),
        .out_link       (out_link),
        .out_redirect   (out_redirect),
        .out_taken      (out_taken),
        .out_halted     (out_halted),
        .out_cnt_cycle  (out_cnt_cycle),
        .out_cnt_uncond (out_cnt_uncond),
        .out_cnt_cond   (out_cnt_cond)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_stall    = 1'b0;
        in_halt     = 1'b0;
        in_go       = 1'b0;
        {in_J, in_JW, in_JR, in_BEQ, in_BNE, in_BGEZ} = 6'b000000;
        in_rs       = 32'd0;
        in_rt       = 32'd0;
        in_imm16    = 16'd0;
        in_target26 = 26'd0;
    endtask

    task automatic check_counters(input string tag);
        check({tag, ".cnt_cycle"},  32'(out_cnt_cycle),  32'(m_cycle));
        check({tag, ".cnt_uncond"}, 32'(out_cnt_uncond), 32'(m_unc));
        check({tag, ".cnt_cond"},   32'(out_cnt_cond),   32'(m_cond));
    endtask

    // Uses a JR to place the PC; the JR itself counts as one cycle and one jump.
    task automatic set_pc(input logic [31:0] v);
        clear_inputs();
        in_JR = 1'b1;
        in_rs = v;
        tick();
        m_cycle = m_cycle + 16'd1;
        m_unc   = m_unc + 16'd1;
        clear_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_cycle  = 16'd0;
        m_unc    = 16'd0;
        m_cond   = 16'd0;

        vecs[0]  = '{32'h0000_0100, 6'b000100, 32'd5, 32'd5, 16'hFFFF, 26'd0, 32'h0000_0100, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{32'h0000_0100, 6'b000100, 32'd5, 32'd6, 16'hFFFF, 26'd0, 32'h0000_0104, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{32'hF000_0010, 6'b010000, 32'd0, 32'd0, 16'h0000, 26'h0000040, 32'hF000_0100, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{32'h0000_0200, 6'b000001, 32'd0, 32'd0, 16'h0010, 26'd0, 32'h0000_0244, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{32'h0000_0200, 6'b000001, 32'h8000_0000, 32'd0, 16'h0010, 26'd0, 32'h0000_0204, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{32'h0000_0300, 6'b001010, 32'h0000_0203, 32'd0, 16'h0010, 26'd0, 32'h0000_0200, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{32'hFFFF_FFF8, 6'b000100, 32'd1, 32'd1, 16'h0001, 26'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{32'h0000_1000, 6'b000010, 32'd1, 32'd2, 16'hFFF0, 26'd0, 32'h0000_0FC4, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{32'h0000_3000, 6'b100000, 32'd0, 32'd0, 16'h0000, 26'h3FFFFFF, 32'h0FFF_FFFC, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{32'h0000_0400, 6'b100100, 32'd0, 32'd0, 16'h0005, 26'h0000010, 32'h0000_0040, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{32'h0000_0500, 6'b000100, 32'd7, 32'd7, 16'h0000, 26'd0, 32'h0000_0504, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{32'h0000_0600, 6'b000000, 32'd9, 32'd3, 16'h1234, 26'h1234567, 32'h0000_0604, 1'b0, 1'b0, 1'b0};

        clear_inputs();
        in_rst = 1'b1;
        tick();
        tick();
        check("reset.pc", out_pc, 32'h0000_0000);
        check("reset.halted", 32'(out_halted), 32'd0);
        check("reset.taken", 32'(out_taken), 32'd0);
        check_counters("reset");
        in_rst = 1'b0;

        // Table-driven single-instruction vectors.
        for (int i = 0; i < NV; i++) begin
            set_pc(vecs[i].pc0);
            check($sformatf("v%0d.start_pc", i), out_pc, vecs[i].pc0);
            {in_J, in_JW, in_JR, in_BEQ, in_BNE, in_BGEZ} = vecs[i].strb;
            in_rs       = vecs[i].rs;
            in_rt       = vecs[i].rt;
            in_imm16    = vecs[i].imm;
            in_target26 = vecs[i].tgt;
            #1;
            check($sformatf("v%0d.link", i), out_link, vecs[i].pc0 + 32'd4);
            check($sformatf("v%0d.redirect", i), 32'(out_redirect), 32'(vecs[i].exp_redir));
            tick();
            m_cycle = m_cycle + 16'd1;
            m_unc   = m_unc + 16'(vecs[i].exp_unc);
            m_cond  = m_cond + 16'(vecs[i].exp_cond);
            check($sformatf("v%0d.pc", i), out_pc, vecs[i].exp_pc);
            check($sformatf("v%0d.taken", i), 32'(out_taken), 32'(vecs[i].exp_redir));
            check_counters($sformatf("v%0d", i));
            clear_inputs();
        end

        // Halt under stall stays in RUN; released stall halts and ignores the jump.
        set_pc(32'h0000_0080);
        in_halt  = 1'b1;
        in_stall = 1'b1;
        tick();
        check("halt_stall.pc", out_pc, 32'h0000_0080);
        check("halt_stall.halted", 32'(out_halted), 32'd0);
        check_counters("halt_stall");
        in_stall    = 1'b0;
        in_J        = 1'b1;
        in_target26 = 26'h0000100;
        tick();
        check("halt_enter.halted", 32'(out_halted), 32'd1);
        check("halt_enter.pc", out_pc, 32'h0000_0080);
        check("halt_enter.taken", 32'(out_taken), 32'd0);
        check_counters("halt_enter");
        clear_inputs();
        in_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("halt_hold%0d.pc", k), out_pc, 32'h0000_0080);
            check($sformatf("halt_hold%0d.halted", k), 32'(out_halted), 32'd1);
            check($sformatf("halt_hold%0d.cnt_cycle", k), 32'(out_cnt_cycle), 32'(m_cycle));
        end
        in_halt = 1'b1;
        in_go   = 1'b1;
        tick();
        check("resume.halted", 32'(out_halted), 32'd0);
        check("resume.pc", out_pc, 32'h0000_0084);
        check_counters("resume");
        clear_inputs();
        tick();
        m_cycle = m_cycle + 16'd1;
        check("after_resume.pc", out_pc, 32'h0000_0088);
        check_counters("after_resume");
        in_halt = 1'b1;
        in_go   = 1'b1;
        tick();
        check("halt_go_run.halted", 32'(out_halted), 32'd1);
        check("halt_go_run.pc", out_pc, 32'h0000_0088);
        clear_inputs();
        in_go = 1'b1;
        tick();
        check("go_only.halted", 32'(out_halted), 32'd0);
        check("go_only.pc", out_pc, 32'h0000_008C);
        clear_inputs();

        // A stalled taken branch must not move the PC or count.
        set_pc(32'h0000_0100);
        in_stall = 1'b1;
        in_BEQ   = 1'b1;
        in_rs    = 32'd5;
        in_rt    = 32'd5;
        in_imm16 = 16'h0010;
        tick();
        check("stall_br.pc", out_pc, 32'h0000_0100);
        check("stall_br.taken", 32'(out_taken), 32'd0);
        check_counters("stall_br");
        in_stall = 1'b0;
        tick();
        m_cycle = m_cycle + 16'd1;
        m_cond  = m_cond + 16'd1;
        check("unstall_br.pc", out_pc, 32'h0000_0144);
        check("unstall_br.taken", 32'(out_taken), 32'd1);
        check_counters("unstall_br");
        clear_inputs();

        // Asynchronous reset between edges.
        set_pc(32'h0000_0040);
        check("pre_rst.pc", out_pc, 32'h0000_0040);
        in_rst = 1'b1;
        #1;
        check("async_rst.pc", out_pc, 32'h0000_0000);
        check("async_rst.halted", 32'(out_halted), 32'd0);
        check("async_rst.taken", 32'(out_taken), 32'd0);
        m_cycle = 16'd0;
        m_unc   = 16'd0;
        m_cond  = 16'd0;
        check_counters("async_rst");
        tick();
        in_rst = 1'b0;

        // Cycle counter wrap after 65536 sequential instructions.
        for (int k = 0; k < 65535; k++) begin
            tick();
        end
        check("wrap_pre.cnt_cycle", 32'(out_cnt_cycle), 32'h0000_FFFF);
        tick();
        check("wrap.cnt_cycle", 32'(out_cnt_cycle), 32'h0000_0000);
        check("wrap.pc", out_pc, 32'h0004_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
